// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC data-memory access sequencer:
// FSM states, access size codes, RAM opcode layout and the alignment rule.
package sparc_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ISSUE,
    CAPTURE,
    DONE,
    TRAP_MA,
    TRAP_TO
  } mem_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // RAM_OpCode = {2'b00, signed, is_store, size}
  localparam int OP_WIDTH      = 6;
  localparam int OP_SIZE_LSB   = 0;
  localparam int OP_STORE_BIT  = 2;
  localparam int OP_SIGNED_BIT = 3;

  // Reserved size code 11 is always treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// 8-bit ISSUE-cycle counter; flags when the last permitted cycle is reached.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam logic [7:0] TERMINAL_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 8'd0;
    end else if (clear) begin
      count_reg <= 8'd0;
    end else if (inc) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign terminal = (count_reg == TERMINAL_COUNT);

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences one load/store through MAR, MDR and RAM, waiting for MFC and
// reporting completion, misalignment or timeout. All outputs are Moore.
module mem_access_sequencer
  import sparc_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic       req,
  input  logic       is_store,
  input  logic [1:0] size,
  input  logic       is_signed,
  input  logic [1:0] addr_lo,
  input  logic       MFC,
  output logic       MAR_Enable,
  output logic       MDR_Enable,
  output logic       MDR_Mux_select,
  output logic       RAM_enable,
  output logic [5:0] RAM_OpCode,
  output logic       busy,
  output logic       done,
  output logic       trap_misaligned,
  output logic       trap_timeout
);

  mem_state_t state_reg, state_next;

  logic       store_reg;
  logic       signed_reg;
  logic [1:0] size_reg;
  logic       accept;
  logic       tmo_terminal;
  logic [OP_WIDTH-1:0] opcode;

  assign accept = (state_reg == IDLE) && req;

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request fields are captured once; the inputs are free to change afterwards.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      store_reg  <= 1'b0;
      signed_reg <= 1'b0;
      size_reg   <= SZ_BYTE;
    end else if (accept) begin
      store_reg  <= is_store;
      signed_reg <= is_signed & ~is_store;
      size_reg   <= size;
    end
  end

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (Clk),
    .rst      (RESET),
    .clear    (state_reg == ADDR),
    .inc      (state_reg == ISSUE),
    .terminal (tmo_terminal)
  );

  always_comb begin
    opcode = '0;
    opcode[OP_SIZE_LSB +: 2] = size_reg;
    opcode[OP_STORE_BIT]     = store_reg;
    opcode[OP_SIGNED_BIT]    = signed_reg;
  end

  always_comb begin
    state_next      = state_reg;
    MAR_Enable      = 1'b0;
    MDR_Enable      = 1'b0;
    MDR_Mux_select  = 1'b0;
    RAM_enable      = 1'b0;
    RAM_OpCode      = '0;
    busy            = (state_reg != IDLE);
    done            = 1'b0;
    trap_misaligned = 1'b0;
    trap_timeout    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = is_misaligned(size, addr_lo) ? TRAP_MA : ADDR;
        end
      end
      ADDR: begin
        MAR_Enable = 1'b1;
        MDR_Enable = store_reg;
        state_next = ISSUE;
      end
      ISSUE: begin
        RAM_enable = 1'b1;
        RAM_OpCode = opcode;
        // A completing MFC beats a simultaneous terminal count.
        if (MFC) begin
          state_next = store_reg ? DONE : CAPTURE;
        end else if (tmo_terminal) begin
          state_next = TRAP_TO;
        end
      end
      CAPTURE: begin
        RAM_enable     = 1'b1;
        RAM_OpCode     = opcode;
        MDR_Enable     = 1'b1;
        MDR_Mux_select = 1'b1;
        state_next     = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      TRAP_MA: begin
        trap_misaligned = 1'b1;
        state_next      = IDLE;
      end
      TRAP_TO: begin
        trap_timeout = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized bench: per transaction the expected cycle-by-cycle output trace
// is built from the timing rules and compared against the DUT outputs.
module tb_mem_access_sequencer;

  localparam int TO = 4;

  logic       Clk = 1'b0;
  logic       RESET = 1'b1;
  logic       req = 1'b0;
  logic       is_store = 1'b0;
  logic [1:0] size = 2'b00;
  logic       is_signed = 1'b0;
  logic [1:0] addr_lo = 2'b00;
  logic       MFC = 1'b0;
  logic       MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable;
  logic [5:0] RAM_OpCode;
  logic       busy, done, trap_misaligned, trap_timeout;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  always #5 Clk = ~Clk;

  mem_access_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk             (Clk),
    .RESET           (RESET),
    .req             (req),
    .is_store        (is_store),
    .size            (size),
    .is_signed       (is_signed),
    .addr_lo         (addr_lo),
    .MFC             (MFC),
    .MAR_Enable      (MAR_Enable),
    .MDR_Enable      (MDR_Enable),
    .MDR_Mux_select  (MDR_Mux_select),
    .RAM_enable      (RAM_enable),
    .RAM_OpCode      (RAM_OpCode),
    .busy            (busy),
    .done            (done),
    .trap_misaligned (trap_misaligned),
    .trap_timeout    (trap_timeout)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output vector: {mar, mdr_en, mdr_mux, ram_en, opcode[5:0], busy, done, trap_ma, trap_to}
  function automatic logic [13:0] observed();
    return {MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
            busy, done, trap_misaligned, trap_timeout};
  endfunction

  function automatic logic [13:0] vec(input logic mar, input logic mdr, input logic mux,
                                      input logic ram, input logic [5:0] op, input logic bsy,
                                      input logic dn, input logic tma, input logic tto);
    return {mar, mdr, mux, ram, op, bsy, dn, tma, tto};
  endfunction

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge Clk);
      check_val($sformatf("idle txn%0d", txn_id), 32'(observed()), 32'(0));
      req = 1'b0;
      MFC = 1'($urandom);
    end
  endtask

  // n = ISSUE cycle (1-based) in which MFC is raised; 0 or > TO means never.
  task automatic run_txn(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [1:0] al, input int n);
    logic mis, ok;
    logic [5:0] op;
    logic [13:0] e;
    int L, last;
    mis  = (sz == 2'd3) || (sz == 2'd1 && al[0]) || (sz == 2'd2 && al != 2'd0);
    op   = {2'b00, sg & ~st, st, sz};
    ok   = (n >= 1) && (n <= TO);
    L    = ok ? n : TO;
    last = mis ? 1 : ((ok && !st) ? 3 + L : 2 + L);
    txn_id++;
    $display("txn%0d: store=%0d size=%0d signed=%0d addr_lo=%0d mfc_at=%0d", txn_id, st, sz, sg, al, n);
    for (int c = 0; c <= last; c++) begin
      @(negedge Clk);
      e = '0;
      if (c == 0) e = '0;
      else if (mis) e = vec(0, 0, 0, 0, 6'd0, 1, 0, 1, 0);
      else if (c == 1) e = vec(1, st, 0, 0, 6'd0, 1, 0, 0, 0);
      else if (c <= 1 + L) e = vec(0, 0, 0, 1, op, 1, 0, 0, 0);
      else if (c == 2 + L) begin
        if (!ok) e = vec(0, 0, 0, 0, 6'd0, 1, 0, 0, 1);
        else if (st) e = vec(0, 0, 0, 0, 6'd0, 1, 1, 0, 0);
        else e = vec(0, 1, 1, 1, op, 1, 0, 0, 0);
      end else e = vec(0, 0, 0, 0, 6'd0, 1, 1, 0, 0);
      check_val($sformatf("txn%0d c%0d", txn_id, c), 32'(observed()), 32'(e));
      if (c == 0) begin
        req = 1'b1; is_store = st; size = sz; is_signed = sg; addr_lo = al;
      end else begin
        req = 1'($urandom); is_store = 1'($urandom); size = 2'($urandom);
        is_signed = 1'($urandom); addr_lo = 2'($urandom);
      end
      if (!mis && c >= 2 && c <= 1 + L) MFC = (c - 1 == n);
      else MFC = 1'($urandom);
    end
  endtask

  task automatic reset_during_issue();
    txn_id++;
    $display("txn%0d: reset during ISSUE", txn_id);
    @(negedge Clk);
    req = 1'b1; is_store = 1'b0; size = 2'b10; is_signed = 1'b0; addr_lo = 2'b00; MFC = 1'b0;
    @(negedge Clk);
    req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check_val("pre_reset_issue", 32'({RAM_enable, busy}), 32'(2'b11));
    RESET = 1'b1;
    #1;
    check_val("async_reset_outputs", 32'(observed()), 32'(0));
    @(negedge Clk);
    RESET = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    check_val("reset_state", 32'(observed()), 32'(0));
    RESET = 1'b0;
    idle_cycles(1);

    run_txn(1'b0, 2'b10, 1'b0, 2'b00, 2);   // word load, MFC in 2nd ISSUE
    run_txn(1'b1, 2'b00, 1'b0, 2'b11, 1);   // byte store, immediate MFC
    run_txn(1'b0, 2'b01, 1'b0, 2'b01, 1);   // misaligned halfword
    run_txn(1'b0, 2'b10, 1'b0, 2'b10, 1);   // misaligned word
    run_txn(1'b0, 2'b11, 1'b1, 2'b00, 1);   // reserved size
    run_txn(1'b0, 2'b10, 1'b0, 2'b00, 0);   // timeout
    run_txn(1'b0, 2'b10, 1'b0, 2'b00, TO);  // MFC on terminal count
    run_txn(1'b1, 2'b01, 1'b1, 2'b10, TO);
    run_txn(1'b0, 2'b01, 1'b1, 2'b10, 3);   // signed halfword load
    idle_cycles(2);
    reset_during_issue();
    run_txn(1'b0, 2'b00, 1'b1, 2'b01, 1);

    for (int i = 0; i < 150; i++) begin
      run_txn(1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), int'($urandom_range(0, TO + 2)));
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end

    idle_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Sequences one data-memory transaction (load or store) through the MAR, MDR and RAM of the SPARC datapath. It sits beside `ControlUnit` and is handed a request when the control unit reaches a load/store execute state. It then drives the MAR/MDR/RAM enables, waits for `MFC`, and returns `done` or a trap pulse. The control unit stalls on `busy`.

## Interface
- `TIMEOUT_CYCLES`, 15: max ISSUE cycles without `MFC` before the timeout trap (range 1–255).
- `Clk` input 1: clock, rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `req` input 1: start transaction; sampled only in IDLE.
- `is_store` input 1: 1 = store, 0 = load.
- `size` input 2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
- `is_signed` input 1: sign-extend load data; ignored for stores.
- `addr_lo` input 2: effective address bits [1:0], used for the alignment check.
- `MFC` input 1: memory function complete from RAM.
- `MAR_Enable` output 1: load MAR from ALU_Out.
- `MDR_Enable` output 1: load MDR.
- `MDR_Mux_select` output 1: 0 = MDR from datapath (store), 1 = MDR from RAM (load).
- `RAM_enable` output 1: RAM operation active.
- `RAM_OpCode` output 6: {2'b00, signed, is_store, size}.
- `busy` output 1: state ≠ IDLE.
- `done` output 1: one-cycle pulse, transaction complete.
- `trap_misaligned` output 1: one-cycle pulse.
- `trap_timeout` output 1: one-cycle pulse.

## Operation
- All outputs are Moore, decoded from the state and the latched request. Reset value of every output is 0.
- `is_store`, `size`, `is_signed` and `addr_lo` are latched on the accepting edge. Inputs are don't-care afterwards.
- Misaligned means any of:
  - size=01 with addr_lo[0]=1;
  - size=10 with addr_lo≠00;
  - size=11.
- States:
  - IDLE: all outputs 0.
    - `req`=1 and aligned → ADDR.
    - `req`=1 and misaligned → TRAP_MA.
    - Otherwise stay in IDLE.
  - ADDR (1 cycle): `MAR_Enable`=1. Store: also `MDR_Enable`=1, `MDR_Mux_select`=0. → ISSUE; the timeout counter clears to 0.
  - ISSUE: `RAM_enable`=1, `RAM_OpCode` valid. The counter increments each cycle.
    - `MFC`=1 → CAPTURE (load) or DONE (store).
    - Counter = TIMEOUT_CYCLES−1 and `MFC`=0 → TRAP_TO.
  - CAPTURE (1 cycle): `RAM_enable`=1, `MDR_Enable`=1, `MDR_Mux_select`=1. → DONE.
  - DONE (1 cycle): `done`=1. → IDLE.
  - TRAP_MA (1 cycle): `trap_misaligned`=1, no MAR/RAM activity. → IDLE.
  - TRAP_TO (1 cycle): `trap_timeout`=1, `RAM_enable`=0. → IDLE.
- `MFC` is ignored outside ISSUE.
- `MFC` and timeout on the same edge: `MFC` wins.
- `req` is ignored while `busy`. A `req` held high starts a new transaction on the first IDLE cycle.

## Timing
- Cycle 0: `req` sampled in IDLE.
- Cycle 1: ADDR.
- Cycle 2: first ISSUE cycle.
- With `MFC` seen at the end of ISSUE cycle n (n ≥ 1):
  - load: `done` at cycle 3+n;
  - store: `done` at cycle 2+n.
- Minimum latency from `req` to `done`: load 4 cycles, store 3 cycles.
- Back-to-back: the next `req` is accepted one cycle after `done`, because DONE returns to IDLE.
- Misaligned: `trap_misaligned` at cycle 1. `MAR_Enable` never asserts.
- Timeout: ISSUE lasts exactly TIMEOUT_CYCLES cycles, then `trap_timeout` is asserted for 1 cycle.
- RESET asserted mid-transaction: state → IDLE and all outputs → 0 immediately (asynchronously). No `done` or trap is produced for the aborted transaction.

## Structure
- Shared package `sparc_mem_pkg`:
  - state enum (IDLE, ADDR, ISSUE, CAPTURE, DONE, TRAP_MA, TRAP_TO);
  - size codes (SZ_BYTE, SZ_HALF, SZ_WORD);
  - `RAM_OpCode` field positions;
  - alignment-check function.
- Sub-module `mem_timeout_counter`: 8-bit counter with clear, increment and terminal-count compare against TIMEOUT_CYCLES−1.
- Everything else is a single FSM in `mem_access_sequencer`.

## Test plan
- Word load, addr_lo=00, is_signed=0, `MFC` raised in the 2nd ISSUE cycle → `MAR_Enable` at cycle 1, `RAM_OpCode`=6'b000010, CAPTURE with `MDR_Mux_select`=1 at cycle 4, `done` at cycle 5.
- Byte store, addr_lo=11, `MFC` high in the first ISSUE cycle → `MDR_Enable`=1 with `MDR_Mux_select`=0 at cycle 1, `RAM_OpCode`=6'b000100, `done` at cycle 3.
- Halfword load with addr_lo=01, and word load with addr_lo=10 → `trap_misaligned` at cycle 1, `MAR_Enable` and `RAM_enable` stay 0, `busy` returns to 0 at cycle 2.
- TIMEOUT_CYCLES=4 and `MFC` held 0 → `RAM_enable` high for cycles 2–5, `trap_timeout` at cycle 6, no `done`.
- `MFC` and terminal count on the same edge (TIMEOUT_CYCLES=4, `MFC` in the 4th ISSUE cycle) → `done` is asserted, `trap_timeout` is not.
- RESET pulsed during ISSUE → all outputs 0 within the same cycle; a subsequent `req` completes normally.
